// File: rtl/cache_data_array.sv
// Multi-way cache data store with per-line dirty bits, a registered write-first read port,
// byte-masked word writes and full-line fills. Self-clears one set per cycle after reset.
module cache_data_array #(
   parameter int unsigned LINE_BITS = 128,
   parameter int unsigned WORD_BITS = 16,
   parameter int unsigned SETS      = 8,
   parameter int unsigned WAYS      = 2,
   localparam int unsigned WORDS = LINE_BITS / WORD_BITS,
   localparam int unsigned OFF_W = (WORDS > 1) ? $clog2(WORDS) : 1,
   localparam int unsigned SET_W = $clog2(SETS),
   localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
   localparam int unsigned BE_W  = WORD_BITS / 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 ready,
   input  logic                 rd_en,
   input  logic [SET_W-1:0]     rd_set,
   input  logic [WAY_W-1:0]     rd_way,
   output logic                 rd_valid,
   output logic [LINE_BITS-1:0] rd_line,
   output logic                 rd_dirty,
   input  logic                 wr_en,
   input  logic [SET_W-1:0]     wr_set,
   input  logic [WAY_W-1:0]     wr_way,
   input  logic [OFF_W-1:0]     wr_offset,
   input  logic [BE_W-1:0]      wr_byte_en,
   input  logic [WORD_BITS-1:0] wr_word,
   input  logic                 fill_en,
   input  logic [SET_W-1:0]     fill_set,
   input  logic [WAY_W-1:0]     fill_way,
   input  logic [LINE_BITS-1:0] fill_line
);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   // With a single way the way index is meaningless; masking keeps it in range.
   localparam logic [WAY_W-1:0] WAY_MASK = WAY_W'(WAYS - 1);

   state_e               state_q;
   logic [SET_W-1:0]     cnt_q;
   logic                 ready_q;
   logic                 rd_valid_q;
   logic                 rd_dirty_q;
   logic [LINE_BITS-1:0] rd_line_q;

   logic [LINE_BITS-1:0] data_q  [SETS][WAYS];
   logic [WAYS-1:0]      dirty_q [SETS];

   logic [WAY_W-1:0]     rd_w, wr_w, fill_w;
   logic                 wr_act;
   logic                 fill_hits_wr;
   logic                 rd_hits_wr;
   logic                 rd_hits_fill;
   logic [LINE_BITS-1:0] wr_base;
   logic [LINE_BITS-1:0] wr_merged;
   logic [LINE_BITS-1:0] rd_next_line;
   logic                 rd_next_dirty;
   int unsigned          wr_bit;

   assign rd_w   = rd_way & WAY_MASK;
   assign wr_w   = wr_way & WAY_MASK;
   assign fill_w = fill_way & WAY_MASK;

   always_comb begin
      wr_act       = wr_en && (wr_byte_en != '0);
      fill_hits_wr = fill_en && (fill_set == wr_set) && (fill_w == wr_w);
      rd_hits_wr   = wr_act && (rd_set == wr_set) && (rd_w == wr_w);
      rd_hits_fill = fill_en && (rd_set == fill_set) && (rd_w == fill_w);
      // A same-line fill lands first, so the write merges on top of the fill data.
      wr_base      = fill_hits_wr ? fill_line : data_q[wr_set][wr_w];
      wr_merged    = wr_base;
      wr_bit       = 32'(wr_offset) * WORD_BITS;
      for (int unsigned b = 0; b < BE_W; b++) begin
         if (wr_byte_en[b]) wr_merged[wr_bit + b * 8 +: 8] = wr_word[b * 8 +: 8];
      end
      if (rd_hits_wr) begin
         rd_next_line  = wr_merged;
         rd_next_dirty = 1'b1;
      end else if (rd_hits_fill) begin
         rd_next_line  = fill_line;
         rd_next_dirty = 1'b0;
      end else begin
         rd_next_line  = data_q[rd_set][rd_w];
         rd_next_dirty = dirty_q[rd_set][rd_w];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StInit;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_line_q  <= '0;
         rd_dirty_q <= 1'b0;
      end else if (state_q == StInit) begin
         cnt_q      <= cnt_q + SET_W'(1);
         rd_valid_q <= 1'b0;
         if (cnt_q == SET_W'(SETS - 1)) begin
            state_q <= StRun;
            ready_q <= 1'b1;
         end
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_line_q  <= rd_next_line;
            rd_dirty_q <= rd_next_dirty;
         end
      end
   end

   // Storage is not reset directly; the INIT sweep clears it one set per cycle.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_q == StInit) begin
            for (int unsigned w = 0; w < WAYS; w++) data_q[cnt_q][w] <= '0;
            dirty_q[cnt_q] <= '0;
         end else begin
            if (fill_en) begin
               data_q[fill_set][fill_w]  <= fill_line;
               dirty_q[fill_set][fill_w] <= 1'b0;
            end
            if (wr_act) begin
               data_q[wr_set][wr_w]  <= wr_merged;
               dirty_q[wr_set][wr_w] <= 1'b1;
            end
         end
      end
   end

   assign ready    = ready_q;
   assign rd_valid = rd_valid_q;
   assign rd_line  = rd_line_q;
   assign rd_dirty = rd_dirty_q;

endmodule

// File: tb/tb_cache_data_array.sv
// Directed bench for cache_data_array: init sweep, fills, byte-masked writes, bypass,
// way isolation and reset during operation.
module tb_cache_data_array;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ready;
   logic         rd_en;
   logic [2:0]   rd_set;
   logic [0:0]   rd_way;
   logic         rd_valid;
   logic [127:0] rd_line;
   logic         rd_dirty;
   logic         wr_en;
   logic [2:0]   wr_set;
   logic [0:0]   wr_way;
   logic [2:0]   wr_offset;
   logic [1:0]   wr_byte_en;
   logic [15:0]  wr_word;
   logic         fill_en;
   logic [2:0]   fill_set;
   logic [0:0]   fill_way;
   logic [127:0] fill_line;

   int n_total = 0;
   int n_bad   = 0;

   cache_data_array dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ready      (ready),
      .rd_en      (rd_en),
      .rd_set     (rd_set),
      .rd_way     (rd_way),
      .rd_valid   (rd_valid),
      .rd_line    (rd_line),
      .rd_dirty   (rd_dirty),
      .wr_en      (wr_en),
      .wr_set     (wr_set),
      .wr_way     (wr_way),
      .wr_offset  (wr_offset),
      .wr_byte_en (wr_byte_en),
      .wr_word    (wr_word),
      .fill_en    (fill_en),
      .fill_set   (fill_set),
      .fill_way   (fill_way),
      .fill_line  (fill_line)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      fill_en = 1'b0;
   endtask

   task automatic set_rd(input int s, input int w);
      rd_en  = 1'b1;
      rd_set = 3'(s);
      rd_way = 1'(w);
   endtask

   task automatic set_wr(input int s, input int w, input int off, input logic [1:0] be,
                         input logic [15:0] word);
      wr_en      = 1'b1;
      wr_set     = 3'(s);
      wr_way     = 1'(w);
      wr_offset  = 3'(off);
      wr_byte_en = be;
      wr_word    = word;
   endtask

   task automatic set_fill(input int s, input int w, input logic [127:0] line);
      fill_en   = 1'b1;
      fill_set  = 3'(s);
      fill_way  = 1'(w);
      fill_line = line;
   endtask

   // Issue a lone read, then check the registered result.
   task automatic read_chk(input string tag, input int s, input int w,
                           input logic [127:0] exp_line, input logic exp_dirty);
      idle();
      set_rd(s, w);
      tick();
      idle();
      chk({tag, "_valid"}, 128'(rd_valid), 128'(1'b1));
      chk({tag, "_line"}, rd_line, exp_line);
      chk({tag, "_dirty"}, 128'(rd_dirty), 128'(exp_dirty));
   endtask

   logic [127:0] pat_f;
   logic [127:0] pat_p;
   logic [127:0] exp_line;

   initial begin
      rst_n = 1'b0;
      idle();
      rd_set = '0; rd_way = '0;
      wr_set = '0; wr_way = '0; wr_offset = '0; wr_byte_en = '0; wr_word = '0;
      fill_set = '0; fill_way = '0; fill_line = '0;
      pat_f = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      pat_p = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;

      // Reset and init sweep
      repeat (3) tick();
      chk("rst_ready", 128'(ready), 128'(1'b0));
      chk("rst_valid", 128'(rd_valid), 128'(1'b0));
      chk("rst_line", rd_line, 128'h0);
      chk("rst_dirty", 128'(rd_dirty), 128'(1'b0));
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("init_ready_%0d", i), 128'(ready), 128'(i == 8));
      end
      read_chk("init_rd_5_1", 5, 1, 128'h0, 1'b0);
      tick();
      chk("noread_valid", 128'(rd_valid), 128'(1'b0));

      // Fill then read
      set_fill(3, 0, pat_f);
      tick();
      read_chk("fill_rd", 3, 0, pat_f, 1'b0);
      tick();
      chk("hold_line", rd_line, pat_f);

      // Byte-masked writes
      set_wr(3, 0, 7, 2'b10, 16'hAAAA);
      tick();
      set_wr(3, 0, 0, 2'b01, 16'h5555);
      tick();
      read_chk("bemask", 3, 0, 128'hAA23_4567_89AB_CDEF_FEDC_BA98_7654_3255, 1'b1);

      set_fill(4, 1, pat_p);
      tick();
      idle();
      set_wr(4, 1, 2, 2'b00, 16'hFFFF);
      tick();
      read_chk("be0_clean", 4, 1, pat_p, 1'b0);

      // Simultaneous fill + write + read on one line
      idle();
      set_fill(2, 1, '1);
      set_wr(2, 1, 1, 2'b11, 16'h0000);
      set_rd(2, 1);
      tick();
      idle();
      exp_line = ~(128'hFFFF << 16);
      chk("sim_same_valid", 128'(rd_valid), 128'(1'b1));
      chk("sim_same_line", rd_line, exp_line);
      chk("sim_same_dirty", 128'(rd_dirty), 128'(1'b1));
      read_chk("sim_same_after", 2, 1, exp_line, 1'b1);

      set_fill(2, 1, '1);
      set_wr(2, 0, 1, 2'b11, 16'h1234);
      set_rd(2, 1);
      tick();
      idle();
      chk("sim_diff_line", rd_line, '1);
      chk("sim_diff_dirty", 128'(rd_dirty), 128'(1'b0));
      read_chk("sim_diff_w0", 2, 0, 128'h1234_0000, 1'b1);

      // Way isolation
      set_fill(7, 0, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F);
      tick();
      idle();
      set_fill(7, 1, 128'hA5A5_5A5A_A5A5_5A5A_A5A5_5A5A_A5A5_5A5A);
      tick();
      read_chk("iso_w0", 7, 0, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 1'b0);
      read_chk("iso_w1", 7, 1, 128'hA5A5_5A5A_A5A5_5A5A_A5A5_5A5A_A5A5_5A5A, 1'b0);
      read_chk("iso_s6w0", 6, 0, 128'h0, 1'b0);
      read_chk("iso_s6w1", 6, 1, 128'h0, 1'b0);

      // Reset mid-operation with a read in flight; requests during the sweep are ignored
      set_wr(6, 0, 3, 2'b11, 16'h7777);
      tick();
      idle();
      set_rd(3, 0);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid", 128'(rd_valid), 128'(1'b0));
      chk("mid_rst_ready", 128'(ready), 128'(1'b0));
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         if (i == 5) set_wr(0, 0, 0, 2'b11, 16'hBEEF);
         if (i == 6) wr_en = 1'b0;
         tick();
         chk($sformatf("mid_ready_%0d", i), 128'(ready), 128'(i == 8));
         chk($sformatf("mid_valid_%0d", i), 128'(rd_valid), 128'(1'b0));
      end
      idle();
      for (int s = 0; s < 8; s++) begin
         for (int w = 0; w < 2; w++) begin
            read_chk($sformatf("clr_s%0dw%0d", s, w), s, w, 128'h0, 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/cache_data_array.md
# cache_data_array

Parametrised, multi-way cache data store with per-line dirty tracking. It is the next-generation replacement for the single-way, 8-set, 128-bit data unit. The block serves the cache controller with three ports: a registered read port, a byte-masked word-write port for CPU stores, and a full-line fill port for memory refills. After reset it clears itself with a hardware sweep, so no initial block or simulation-only preload is relied on.

## Interface
Parameters:
- LINE_BITS, 128, bits per cache line; must be a multiple of WORD_BITS.
- WORD_BITS, 16, bits per CPU word; must be a multiple of 8.
- SETS, 8, number of sets; power of two, ≥2.
- WAYS, 2, number of ways; power of two, ≥1.
- Derived values:
  - WORDS = LINE_BITS/WORD_BITS
  - OFF_W = clog2(WORDS)
  - SET_W = clog2(SETS)
  - WAY_W = max(1, clog2(WAYS))
  - BE_W = WORD_BITS/8

Ports:
- clk  in  1  clock. All state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ready  out  1  high when the array accepts commands. Low during reset and during the init sweep.
- rd_en  in  1  read request.
- rd_set  in  SET_W  read set index.
- rd_way  in  WAY_W  read way index.
- rd_valid  out  1  rd_line and rd_dirty hold the result of the previous cycle's accepted read.
- rd_line  out  LINE_BITS  read data.
- rd_dirty  out  1  dirty bit of the line that was read.
- wr_en  in  1  word write request.
- wr_set  in  SET_W  write set index.
- wr_way  in  WAY_W  write way index.
- wr_offset  in  OFF_W  word index within the line. Word k occupies bits [k*WORD_BITS +: WORD_BITS].
- wr_byte_en  in  BE_W  byte mask. Bit i enables word bits [8i+7:8i].
- wr_word  in  WORD_BITS  write data.
- fill_en  in  1  full-line fill request.
- fill_set  in  SET_W  fill set index.
- fill_way  in  WAY_W  fill way index.
- fill_line  in  LINE_BITS  fill data.

## Operation
States: INIT and RUN.

INIT:
- Entered whenever rst_n=0 at a rising edge. Sweep counter is set to 0.
- Each edge in INIT with rst_n=1 clears data and dirty for every way of set[counter], then increments the counter.
- When the set cleared is SETS-1, the state moves to RUN.
- While in INIT, rd_en, wr_en and fill_en are ignored. ready=0.

RUN (ready=1):
- **Fill.** Writes fill_line to the addressed line and clears its dirty bit.
- **Write.** Merges wr_word into the word at wr_offset, only in the bytes where wr_byte_en is set. Sets the line's dirty bit if wr_byte_en≠0. A write with wr_byte_en=0 changes nothing, including dirty.
- **Fill and write in the same cycle, same set/way.** The fill is applied first and the write is merged on top. The resulting dirty bit is 1 if wr_byte_en≠0.
- **Fill and write in the same cycle, different lines.** Both are applied independently.
- **Read.** Registered. On the edge after an accepted rd_en:
  - rd_valid=1;
  - rd_line and rd_dirty hold the addressed line's state as updated by any fill or write accepted in the same cycle (write-first bypass).
- **Cycle with no read.** rd_valid=0, and rd_line and rd_dirty hold their last value.

Reset values:
- ready=0
- rd_valid=0
- rd_line=0
- rd_dirty=0
- state=INIT, counter=0

Reset mid-operation:
- An rst_n=0 edge during RUN or INIT returns the block to INIT with counter=0.
- Any in-flight read is dropped (rd_valid=0).
- The full sweep then repeats.

## Timing
- Init: ready goes high exactly SETS edges after the first rising edge with rst_n=1. For example, with SETS=8, ready is high after the 8th such edge.
- Read latency: 1 cycle. A read can be accepted every cycle.
- Write and fill: take effect at the accepting edge. A read in the next cycle sees the new data; a read in the same cycle also sees it through the bypass.
- Clearing a set during INIT takes 1 cycle per set, covering all ways in parallel.
- No backpressure in RUN; every request is accepted.

## Test plan
- **Reset/init.** Hold rst_n=0 for 3 edges, then release.
  - ready=0 for the following 8 edges, then 1.
  - A read of set 5 way 1 then returns rd_line=0, rd_dirty=0, rd_valid=1 one cycle later.
- **Fill then read.** Fill set 3 way 0 with 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, then read it next cycle.
  - rd_line equals the fill data, rd_dirty=0.
- **Byte-masked writes.** On the filled line, write wr_offset=7, wr_word=16'hAAAA with wr_byte_en=2'b10, then wr_offset=0, wr_word=16'h5555 with wr_byte_en=2'b01.
  - Bits [127:112]=16'hAA23, bits [15:0]=16'h3255, rd_dirty=1.
  - A write with wr_byte_en=2'b00 to a clean line leaves rd_dirty=0.
- **Simultaneous events.** In one cycle, fill set 2 way 1 with all-ones, write offset 1 with wr_word=16'h0000 and wr_byte_en=2'b11 to the same line, and read the same line.
  - The next cycle shows rd_line=~(128'hFFFF<<16), rd_dirty=1.
  - The same cycle with the write targeting way 0 instead leaves way 1 all-ones with dirty=0.
- **Way isolation.** Fill way 0 and way 1 of set 7 with distinct patterns.
  - Each reads back its own pattern. Set 6 remains 0.
- **Reset mid-operation.** After dirtying several lines, assert rst_n=0 for 1 edge while a read is issued.
  - rd_valid=0 next cycle and ready=0 for 8 edges.
  - All lines then read 0 and clean.
